// File: rtl/character_vertical_mover_pkg.sv
// Shared tile codes, motion state type and tile classification for the vertical mover.
package mover_pkg;

    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;

    typedef enum logic [1:0] {
        STANDING,
        RISING,
        FALLING
    } mover_state_t;

    function automatic logic is_solid(input logic [7:0] tile);
        case (tile)
            BDR, BLK, GND: return 1'b1;
            SKY, TKN:      return 1'b0;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/character_vertical_mover_if.sv
// Control, background and motion-result signals between the game logic and the vertical mover.
interface character_vertical_mover_if #(
    parameter int GRID_ROWS = 12,
    parameter int GRID_COLS = 17,
    parameter int Y_W       = 12,
    parameter int VEL_W     = 7
);
    logic                                       jump;
    logic                                       freeze;
    logic                                       respawn;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0][7:0]   background;
    logic signed [Y_W-1:0]                      char_x;
    logic signed [Y_W-1:0]                      char_y;
    logic signed [VEL_W-1:0]                    velocity_y;
    logic                                       grounded;
    logic                                       landed;
    logic                                       bonk;
    logic                                       fell_out;

    modport master (
        output jump, freeze, respawn, background, char_x,
        input  char_y, velocity_y, grounded, landed, bonk, fell_out
    );

    modport slave (
        input  jump, freeze, respawn, background, char_x,
        output char_y, velocity_y, grounded, landed, bonk, fell_out
    );
endinterface

// File: rtl/character_vertical_mover_tile_probe.sv
// Looks up one pixel row under three sprite columns and reports whether any tile there is solid.
module tile_probe
    import mover_pkg::*;
#(
    parameter int GRID_ROWS       = 12,
    parameter int GRID_COLS       = 17,
    parameter int BLOCK_WIDTH     = 40,
    parameter int CHARACTER_WIDTH = 42,
    parameter int Y_W             = 12
) (
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][7:0] background,
    input  logic signed [Y_W:0]                      pix_y,
    input  logic signed [Y_W-1:0]                    char_x,
    output logic                                     any_solid
);
    localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;

    localparam logic [Y_W:0]        BW_U       = (Y_W+1)'(BLOCK_WIDTH);
    localparam logic [Y_W:0]        ROWS_U     = (Y_W+1)'(GRID_ROWS);
    localparam logic [Y_W:0]        LAST_COL_U = (Y_W+1)'(GRID_COLS - 1);
    localparam logic signed [Y_W:0] OFF_L      = (Y_W+1)'(1);
    localparam logic signed [Y_W:0] OFF_M      = (Y_W+1)'(CHARACTER_WIDTH / 2);
    localparam logic signed [Y_W:0] OFF_R      = (Y_W+1)'(CHARACTER_WIDTH - 2);

    function automatic logic [CW-1:0] col_of(input logic signed [Y_W:0] px);
        logic [Y_W:0] q;
        q = $unsigned(px) / BW_U;
        if (px[Y_W])
            return '0;
        if (q > LAST_COL_U)
            return LAST_COL_U[CW-1:0];
        return q[CW-1:0];
    endfunction

    logic signed [Y_W:0] cx_e;
    logic [Y_W:0]        row_full;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col_l, col_m, col_r;

    // Rows above the screen act as border; rows below it are an open pit.
    always_comb begin
        cx_e     = {char_x[Y_W-1], char_x};
        col_l    = col_of(cx_e + OFF_L);
        col_m    = col_of(cx_e + OFF_M);
        col_r    = col_of(cx_e + OFF_R);
        row_full = $unsigned(pix_y) / BW_U;
        row      = row_full[RW-1:0];
        if (pix_y[Y_W])
            any_solid = 1'b1;
        else if (row_full >= ROWS_U)
            any_solid = 1'b0;
        else
            any_solid = is_solid(background[row][col_l])
                      | is_solid(background[row][col_m])
                      | is_solid(background[row][col_r]);
    end

endmodule

// File: rtl/character_vertical_mover.sv
// Velocity/gravity vertical motion engine with tile collision for one character.
// Optional VARIABLE_JUMP_EN: releasing jump while rising caps upward speed at JUMP_CUT_SPEED.
module character_vertical_mover
    import mover_pkg::*;
#(
    parameter int GRID_ROWS        = 12,
    parameter int GRID_COLS        = 17,
    parameter int BLOCK_WIDTH      = 40,
    parameter int CHARACTER_WIDTH  = 42,
    parameter int CHARACTER_HEIGHT = 42,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int Y_W              = 12,
    parameter int VEL_W            = 7,
    parameter int SPAWN_Y          = 358,
    parameter int JUMP_VELOCITY    = 12,
    parameter int GRAVITY_PERIOD   = 3,
    parameter int MAX_FALL_SPEED   = 10,
    parameter int JUMP_CUT_SPEED   = 3
) (
    input logic                       movement_clock,
    input logic                       reset,
    character_vertical_mover_if.slave bus
);
`ifdef VARIABLE_JUMP_EN
    localparam bit CUT_EN = 1'b1;
`else
    localparam bit CUT_EN = 1'b0;
`endif
    localparam int GW = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;

    localparam logic [GW-1:0]          GRAV_LAST  = GW'(GRAVITY_PERIOD - 1);
    localparam logic [GW-1:0]          GRAV_ONE   = GW'(1);
    localparam logic signed [Y_W-1:0]  Y_SPAWN    = Y_W'(SPAWN_Y);
    localparam logic signed [Y_W:0]    Y_SPAWN_E  = (Y_W+1)'(SPAWN_Y);
    localparam logic signed [Y_W:0]    H_E        = (Y_W+1)'(CHARACTER_HEIGHT);
    localparam logic signed [Y_W:0]    H_M1_E     = (Y_W+1)'(CHARACTER_HEIGHT - 1);
    localparam logic signed [Y_W:0]    SCREEN_E   = (Y_W+1)'(SCREEN_HEIGHT);
    localparam logic [Y_W:0]           BW_U       = (Y_W+1)'(BLOCK_WIDTH);
    localparam logic [Y_W:0]           H_U        = (Y_W+1)'(CHARACTER_HEIGHT);
    localparam logic [Y_W:0]           ONE_U      = (Y_W+1)'(1);
    localparam logic signed [VEL_W-1:0] V_ZERO    = '0;
    localparam logic signed [VEL_W-1:0] V_ONE     = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] V_MAX     = VEL_W'(MAX_FALL_SPEED);
    localparam logic signed [VEL_W-1:0] V_JUMP    = VEL_W'(-JUMP_VELOCITY);
    localparam logic signed [VEL_W-1:0] V_CUT     = VEL_W'(-JUMP_CUT_SPEED);

    mover_state_t             state_q, state_d;
    logic signed [Y_W-1:0]    y_q, y_d;
    logic signed [VEL_W-1:0]  v_q, v_d;
    logic [GW-1:0]            grav_q, grav_d;
    logic                     jump_prev_q, jump_prev_d;
    logic                     landed_q, landed_d;
    logic                     bonk_q, bonk_d;
    logic                     fell_out_q, fell_out_d;

    logic signed [Y_W:0]      y_e, v_e, ny, move_y, stand_y, y_new;
    logic [Y_W:0]             row_up, row_dn;
    logic signed [VEL_W-1:0]  v_grav;
    logic                     grav_wrap, jump_edge, move_solid, stand_solid;

    always_ff @(posedge movement_clock) begin
        if (reset) begin
            state_q     <= STANDING;
            y_q         <= Y_SPAWN;
            v_q         <= '0;
            grav_q      <= '0;
            jump_prev_q <= 1'b0;
            landed_q    <= 1'b0;
            bonk_q      <= 1'b0;
            fell_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            v_q         <= v_d;
            grav_q      <= grav_d;
            jump_prev_q <= jump_prev_d;
            landed_q    <= landed_d;
            bonk_q      <= bonk_d;
            fell_out_q  <= fell_out_d;
        end
    end

    // Head probe looks at the new top edge when rising, feet probe at the new bottom edge when falling.
    always_comb begin
        y_e     = {y_q[Y_W-1], y_q};
        v_e     = {{(Y_W+1-VEL_W){v_q[VEL_W-1]}}, v_q};
        ny      = y_e + v_e;
        move_y  = v_q[VEL_W-1] ? ny : ny + H_M1_E;
        stand_y = y_e + H_E;
    end

    tile_probe #(
        .GRID_ROWS(GRID_ROWS), .GRID_COLS(GRID_COLS), .BLOCK_WIDTH(BLOCK_WIDTH),
        .CHARACTER_WIDTH(CHARACTER_WIDTH), .Y_W(Y_W)
    ) u_move_probe (
        .background(bus.background), .pix_y(move_y), .char_x(bus.char_x), .any_solid(move_solid)
    );

    tile_probe #(
        .GRID_ROWS(GRID_ROWS), .GRID_COLS(GRID_COLS), .BLOCK_WIDTH(BLOCK_WIDTH),
        .CHARACTER_WIDTH(CHARACTER_WIDTH), .Y_W(Y_W)
    ) u_stand_probe (
        .background(bus.background), .pix_y(stand_y), .char_x(bus.char_x), .any_solid(stand_solid)
    );

    always_comb begin
        state_d     = state_q;
        y_new       = y_e;
        v_d         = v_q;
        grav_d      = grav_q;
        jump_prev_d = jump_prev_q;
        landed_d    = 1'b0;
        bonk_d      = 1'b0;
        fell_out_d  = fell_out_q;
        grav_wrap   = (grav_q == GRAV_LAST);
        v_grav      = grav_wrap ? ((v_q >= V_MAX) ? V_MAX : v_q + V_ONE) : v_q;
        row_up      = $unsigned(ny) / BW_U;
        row_dn      = $unsigned(move_y) / BW_U;
        jump_edge   = bus.jump & ~jump_prev_q;

        if (bus.freeze) begin
            state_d = state_q;
        end else if (bus.respawn) begin
            state_d     = STANDING;
            y_new       = Y_SPAWN_E;
            v_d         = '0;
            grav_d      = '0;
            jump_prev_d = 1'b0;
            fell_out_d  = 1'b0;
        end else begin
            jump_prev_d = bus.jump;
            if (!fell_out_q) begin
                case (state_q)
                    STANDING: begin
                        if (!stand_solid) begin
                            state_d = FALLING;
                            v_d     = '0;
                        end else if (jump_edge) begin
                            state_d = RISING;
                            v_d     = V_JUMP;
                        end
                    end
                    RISING, FALLING: begin
                        grav_d = grav_wrap ? '0 : grav_q + GRAV_ONE;
                        v_d    = v_grav;
                        if (v_q[VEL_W-1]) begin
                            if (ny[Y_W]) begin
                                y_new   = '0;
                                v_d     = '0;
                                state_d = FALLING;
                                bonk_d  = 1'b1;
                            end else if (move_solid) begin
                                y_new   = $signed((row_up + ONE_U) * BW_U);
                                v_d     = '0;
                                state_d = FALLING;
                                bonk_d  = 1'b1;
                            end else begin
                                y_new = ny;
                            end
                        end else if (v_q != V_ZERO) begin
                            if (move_solid) begin
                                y_new    = $signed(row_dn * BW_U - H_U);
                                v_d      = '0;
                                state_d  = STANDING;
                                landed_d = 1'b1;
                                grav_d   = '0;
                            end else begin
                                y_new = ny;
                            end
                        end
                        if (CUT_EN && state_d == RISING && !bus.jump && v_d < V_CUT)
                            v_d = V_CUT;
                        if (state_d == RISING && v_d >= V_ZERO)
                            state_d = FALLING;
                        fell_out_d = (y_new >= SCREEN_E);
                    end
                    default: state_d = state_q;
                endcase
            end
        end
        y_d = y_new[Y_W-1:0];
    end

    always_comb begin
        bus.char_y     = y_q;
        bus.velocity_y = v_q;
        bus.grounded   = (state_q == STANDING);
        bus.landed     = landed_q;
        bus.bonk       = bonk_q;
        bus.fell_out   = fell_out_q;
    end

endmodule

// File: tb/tb_character_vertical_mover.sv
// Randomised scenarios for character_vertical_mover checked tick by tick against a pixel-level model.
module tb_character_vertical_mover;
    import mover_pkg::*;

    localparam int ROWS = 12;
    localparam int COLS = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    character_vertical_mover_if #(.GRID_ROWS(ROWS), .GRID_COLS(COLS), .Y_W(12), .VEL_W(7)) bus ();

    character_vertical_mover #(
        .GRID_ROWS(ROWS), .GRID_COLS(COLS), .BLOCK_WIDTH(40), .CHARACTER_WIDTH(42),
        .CHARACTER_HEIGHT(42), .SCREEN_HEIGHT(480), .Y_W(12), .VEL_W(7), .SPAWN_Y(358),
        .JUMP_VELOCITY(12), .GRAVITY_PERIOD(3), .MAX_FALL_SPEED(10), .JUMP_CUT_SPEED(3)
    ) dut (
        .movement_clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dmin_y   = 9999;
    int dmax_v   = -99;

    // Model: pixel top-y, velocity, ticks since last gravity step, airborne/rising flags.
    int m_y, m_v, m_g;
    bit m_air, m_up, m_jp, m_land, m_bonk, m_fell;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s tick=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    endtask

    function automatic bit m_solid(input int py, input int cx);
        int row, col;
        int offs[3] = '{1, 21, 40};
        if (py < 0) return 1'b1;
        row = py / 40;
        if (row >= ROWS) return 1'b0;
        foreach (offs[i]) begin
            col = cx + offs[i];
            col = (col < 0) ? 0 : col / 40;
            if (col > COLS - 1) col = COLS - 1;
            if (bus.background[row][col] inside {BDR, BLK, GND}) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int ny, ov, cx;
        bit jedge;
        cx = int'(bus.char_x);
        if (rst || (!bus.freeze && bus.respawn)) begin
            m_y = 358; m_v = 0; m_g = 0; m_air = 0; m_up = 0;
            m_jp = 0; m_land = 0; m_bonk = 0; m_fell = 0;
            return;
        end
        m_land = 0;
        m_bonk = 0;
        if (bus.freeze) return;
        jedge = bus.jump && !m_jp;
        m_jp  = bus.jump;
        if (m_fell) return;
        if (!m_air) begin
            if (!m_solid(m_y + 42, cx)) begin
                m_air = 1; m_up = 0; m_v = 0;
            end else if (jedge) begin
                m_air = 1; m_up = 1; m_v = -12;
            end
            return;
        end
        ov = m_v;
        ny = m_y + ov;
        m_g++;
        if (m_g == 3) begin
            m_g = 0;
            if (m_v < 10) m_v++;
        end
        if (ov < 0) begin
            if (ny < 0) begin
                m_y = 0; m_v = 0; m_up = 0; m_bonk = 1;
            end else if (m_solid(ny, cx)) begin
                m_y = (ny / 40 + 1) * 40; m_v = 0; m_up = 0; m_bonk = 1;
            end else m_y = ny;
        end else if (ov > 0) begin
            if (m_solid(ny + 41, cx)) begin
                m_y = (ny + 41) / 40 * 40 - 42; m_v = 0;
                m_air = 0; m_up = 0; m_land = 1; m_g = 0;
            end else m_y = ny;
        end
`ifdef VARIABLE_JUMP_EN
        if (m_up && !bus.jump && m_v < -3) m_v = -3;
`endif
        if (m_up && m_v >= 0) m_up = 0;
        if (m_y >= 480) m_fell = 1;
    endtask

    task automatic tick();
        cyc++;
        @(posedge clk);
        model_step();
        #1;
        check("char_y", int'(bus.char_y), m_y);
        check("velocity_y", int'(bus.velocity_y), m_v);
        check("grounded", int'(bus.grounded), int'(!m_air));
        check("landed", int'(bus.landed), int'(m_land));
        check("bonk", int'(bus.bonk), int'(m_bonk));
        check("fell_out", int'(bus.fell_out), int'(m_fell));
        if (int'(bus.char_y) < dmin_y) dmin_y = int'(bus.char_y);
        if (int'(bus.velocity_y) > dmax_v) dmax_v = int'(bus.velocity_y);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic flat_bg();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bus.background[r][c] = (r >= 10) ? GND : SKY;
    endtask

    initial begin
        int bonk_seen, bonk_y, x;
        bus.jump = 1'b0; bus.freeze = 1'b0; bus.respawn = 1'b0;
        bus.char_x = 12'sd200;
        flat_bg();
        rst = 1'b1;
        run(2);
        check("reset_y", int'(bus.char_y), 358);
        check("reset_grounded", int'(bus.grounded), 1);
        rst = 1'b0;
        run(50);
        check("idle_y", int'(bus.char_y), 358);

        // Full jump held past the apex, then released.
        dmin_y = 9999; dmax_v = -99;
        bus.jump = 1'b1; run(40);
        bus.jump = 1'b0; run(60);
        check("full_apex", dmin_y, 124);
        check("vel_saturate", dmax_v, 10);
        check("full_landed", int'(bus.char_y), 358);

        // Short press: only caps the hop when the variable-jump build is active.
        dmin_y = 9999;
        bus.jump = 1'b1; run(2);
        bus.jump = 1'b0; run(90);
`ifdef VARIABLE_JUMP_EN
        check("short_hop_lower", int'(dmin_y > 124), 1);
`endif

        // Button held across a landing must not re-trigger.
        bus.jump = 1'b1; run(110);
        check("no_rejump", int'(bus.grounded), 1);
        bus.jump = 1'b0; run(2);

        // Ceiling block in row 7 above the character.
        for (int c = 3; c <= 8; c++) bus.background[7][c] = BLK;
        bus.jump = 1'b1; tick(); bus.jump = 1'b0;
        bonk_seen = 0; bonk_y = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.bonk) begin bonk_seen = 1; bonk_y = int'(bus.char_y); break; end
        end
        check("bonk_seen", bonk_seen, 1);
        check("bonk_snap_y", bonk_y, 320);
        run(60);
        check("bonk_relanded", int'(bus.char_y), 358);
        flat_bg();

        // Freeze in mid-air, then resume.
        bus.jump = 1'b1; tick(); bus.jump = 1'b0;
        run($urandom_range(5, 25));
        bus.freeze = 1'b1; bus.jump = 1'b1; run(20);
        bus.freeze = 1'b0; bus.jump = 1'b0; run(90);

        // Walk right off a ledge into a pit.
        for (int r = 10; r < ROWS; r++)
            for (int c = 9; c < COLS; c++) bus.background[r][c] = SKY;
        x = 200;
        for (int i = 0; i < 200 && !bus.fell_out; i++) begin
            if (!m_air) x += 4;
            bus.char_x = 12'(x);
            tick();
        end
        check("pit_fell_out", int'(bus.fell_out), 1);
        run(3);
        bus.respawn = 1'b1; bus.char_x = 12'sd200; tick();
        bus.respawn = 1'b0;
        check("respawn_y", int'(bus.char_y), 358);
        check("respawn_clear", int'(bus.fell_out), 0);
        flat_bg();
        run(3);

        // Random levels with random input activity.
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < COLS; c++) begin
                    int k = $urandom_range(0, 11);
                    bus.background[r][c] = (k == 0) ? BLK : (k == 1) ? TKN : SKY;
                end
            for (int c = 0; c < COLS; c++) begin
                bus.background[10][c] = ($urandom_range(0, 5) == 0) ? SKY : GND;
                bus.background[11][c] = bus.background[10][c];
            end
            x = 200;
            bus.respawn = 1'b1; bus.char_x = 12'(x); tick(); bus.respawn = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 5) == 0) bus.jump = ~bus.jump;
                bus.freeze  = ($urandom_range(0, 19) == 0);
                bus.respawn = m_fell || ($urandom_range(0, 199) == 0);
                x += $urandom_range(0, 8) - 4;
                if (x < -20) x = -20;
                if (x > 660) x = 660;
                bus.char_x = 12'(x);
                tick();
            end
            bus.jump = 1'b0; bus.freeze = 1'b0; bus.respawn = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
